// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use bubbles, taken-branch flushes and
// data-memory wait stalls with a timeout watchdog and saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_branch,
  input  logic             exmem_alu_zero,
  input  logic [63:0]      exmem_pc_branch,
  input  logic             exmem_mem_read,
  input  logic             exmem_mem_write,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             pipe_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_sel,
  output logic [63:0]      pc_target,
  output logic             mem_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       taken, mem_acc, load_use, mem_busy, flush_now, stall_now;

  assign taken    = exmem_branch & exmem_alu_zero;
  assign mem_acc  = exmem_mem_read | exmem_mem_write;
  assign mem_busy = mem_acc & ~dmem_ready;
  assign load_use = idex_mem_read & (idex_rd != 5'd0) &
                    ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  assign pipe_stall  = mem_busy | (state == S_ERR);
  assign pc_target   = exmem_pc_branch;
  assign mem_timeout = (state == S_ERR);
  assign ctrl_state  = state;

  assign flush_now = ~pipe_stall & taken;
  assign stall_now = pipe_stall | (~taken & load_use);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_sel      = 1'b0;
    if (pipe_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (taken) begin
      pc_sel      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // The first not-ready cycle is spent in RUN, so the watchdog trips after MAX_WAIT+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        S_RUN: begin
          wait_cnt <= 8'd0;
          if (mem_busy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (dmem_ready) begin
            state    <= S_RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_now && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_now && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario tasks plus a randomized run against a rule-level model of the hazard controller.
module tb_pipeline_hazard_ctrl;
  localparam int MW = 4;
  localparam int CW = 8;

  logic clk = 0, rst = 0;
  logic [4:0] ifid_rs1 = 0, ifid_rs2 = 0, idex_rd = 0;
  logic idex_mem_read = 0, exmem_branch = 0, exmem_alu_zero = 0;
  logic [63:0] exmem_pc_branch = 0;
  logic exmem_mem_read = 0, exmem_mem_write = 0, dmem_ready = 0;
  logic pc_write, ifid_write, idex_bubble, pipe_stall, ifid_flush, idex_flush, exmem_flush, pc_sel;
  logic [63:0] pc_target;
  logic mem_timeout;
  logic [1:0] ctrl_state;
  logic [CW-1:0] stall_cycles, flush_events;

  int checks = 0, failures = 0;

  // model state: streak counts consecutive not-ready cycles since the stall began
  int m_streak, m_stall, m_flush;
  bit m_err;

  pipeline_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .exmem_branch(exmem_branch),
    .exmem_alu_zero(exmem_alu_zero), .exmem_pc_branch(exmem_pc_branch),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble), .pipe_stall(pipe_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pc_sel(pc_sel),
    .pc_target(pc_target), .mem_timeout(mem_timeout), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .flush_events(flush_events));

  always #5 clk = ~clk;

  function automatic bit f_taken(); return exmem_branch && exmem_alu_zero; endfunction
  function automatic bit f_busy(); return (exmem_mem_read || exmem_mem_write) && !dmem_ready; endfunction
  function automatic bit f_lu();
    return idex_mem_read && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  endfunction

  // {pc_write, ifid_write, idex_bubble, pipe_stall, ifid_flush, idex_flush, exmem_flush, pc_sel}
  function automatic logic [7:0] model_out();
    bit st = m_err || f_busy();
    if (st) return 8'b0001_0000;
    if (f_taken()) return 8'b1100_1111;
    if (f_lu()) return 8'b0010_0000;
    return 8'b1100_0000;
  endfunction

  function automatic int cap(int v); return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v; endfunction

  task automatic tick();
    bit st = m_err || f_busy();
    int ns = m_streak, nst = m_stall, nfl = m_flush;
    bit ne = m_err;
    if (st || (f_lu() && !f_taken())) nst = cap(m_stall + 1);
    if (!st && f_taken()) nfl = cap(m_flush + 1);
    if (!m_err) begin
      if (m_streak == 0) begin
        if (f_busy()) ns = 1;
      end else if (dmem_ready) ns = 0;
      else begin
        ns = m_streak + 1;
        if (ns == MW + 1) ne = 1;
      end
    end
    @(posedge clk);
    m_streak = ns; m_stall = nst; m_flush = nfl; m_err = ne;
    #1;
  endtask

  task automatic idle_inputs();
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0; idex_mem_read = 0;
    exmem_branch = 0; exmem_alu_zero = 0; exmem_pc_branch = 0;
    exmem_mem_read = 0; exmem_mem_write = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 0; #2;
    m_streak = 0; m_stall = 0; m_flush = 0; m_err = 0;
    rst = 1; #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 0; #1;
    checks++;
    if ({ctrl_state, mem_timeout, stall_cycles, flush_events} !== '0) begin
      failures++;
      $display("FAIL reset_state got st=%0d to=%0b sc=%0d fe=%0d want all 0",
               ctrl_state, mem_timeout, stall_cycles, flush_events);
    end
    checks++;
    if ({pipe_stall, pc_write} !== 2'b01) begin
      failures++; $display("FAIL reset_comb got stall=%0b pcw=%0b want 0/1", pipe_stall, pc_write);
    end
    m_streak = 0; m_stall = 0; m_flush = 0; m_err = 0;
    rst = 1; #1;
  endtask

  task automatic test_load_use();
    idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_rs1 = 7; #1;
    checks++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
      failures++; $display("FAIL load_use_ctrl got %b want 001", {pc_write, ifid_write, idex_bubble});
    end
    tick();
    idle_inputs(); #1;
    checks++;
    if (stall_cycles !== 1 || pc_write !== 1) begin
      failures++; $display("FAIL load_use_count got sc=%0d pcw=%0b want 1/1", stall_cycles, pc_write);
    end
  endtask

  task automatic test_x0();
    idex_mem_read = 1; idex_rd = 0; ifid_rs1 = 0; #1;
    checks++;
    if ({pc_write, idex_bubble} !== 2'b10) begin
      failures++; $display("FAIL x0_no_stall got %b want 10", {pc_write, idex_bubble});
    end
    tick();
    checks++;
    if (stall_cycles !== 1) begin failures++; $display("FAIL x0_count got %0d want 1", stall_cycles); end
    idle_inputs(); #1;
  endtask

  task automatic test_branch();
    idex_mem_read = 1; idex_rd = 3; ifid_rs1 = 3;
    exmem_branch = 1; exmem_alu_zero = 1; exmem_pc_branch = 64'h1000; #1;
    checks++;
    if ({pc_sel, ifid_flush, idex_flush, exmem_flush, idex_bubble, pc_write} !== 6'b111101 ||
        pc_target !== 64'h1000) begin
      failures++;
      $display("FAIL branch_ctrl got %b tgt=%h want 111101 tgt=1000",
               {pc_sel, ifid_flush, idex_flush, exmem_flush, idex_bubble, pc_write}, pc_target);
    end
    tick();
    idle_inputs(); #1;
    checks++;
    if (flush_events !== 1 || stall_cycles !== 1) begin
      failures++; $display("FAIL branch_count got fe=%0d sc=%0d want 1/1", flush_events, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_st [3] = '{2'd0, 2'd1, 2'd1};
    do_reset();
    exmem_mem_read = 1; dmem_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pipe_stall !== 1 || ctrl_state !== exp_st[i]) begin
        failures++; $display("FAIL mem_wait_c%0d got stall=%0b st=%0d want 1/%0d", i, pipe_stall, ctrl_state, exp_st[i]);
      end
      tick();
    end
    dmem_ready = 1; #1;
    checks++;
    if (pipe_stall !== 0) begin failures++; $display("FAIL mem_wait_release got stall=%0b want 0", pipe_stall); end
    tick();
    checks++;
    if (ctrl_state !== 0 || stall_cycles !== 3) begin
      failures++; $display("FAIL mem_wait_end got st=%0d sc=%0d want 0/3", ctrl_state, stall_cycles);
    end
    idle_inputs(); #1;
  endtask

  task automatic test_timeout();
    do_reset();
    exmem_mem_read = 1; dmem_ready = 0; #1;
    for (int i = 0; i < MW + 1; i++) begin
      checks++;
      if (ctrl_state === 2'd2) begin failures++; $display("FAIL timeout_early cyc=%0d got st=2 want <2", i); end
      tick();
    end
    checks++;
    if (ctrl_state !== 2'd2 || mem_timeout !== 1) begin
      failures++; $display("FAIL timeout_err got st=%0d to=%0b want 2/1", ctrl_state, mem_timeout);
    end
    exmem_mem_read = 0; dmem_ready = 1; tick();
    checks++;
    if (ctrl_state !== 2'd2 || mem_timeout !== 1 || pipe_stall !== 1) begin
      failures++; $display("FAIL timeout_sticky got st=%0d to=%0b stall=%0b want 2/1/1", ctrl_state, mem_timeout, pipe_stall);
    end
    rst = 0; #1;
    checks++;
    if (ctrl_state !== 0 || mem_timeout !== 0 || pipe_stall !== 0) begin
      failures++; $display("FAIL timeout_clear got st=%0d to=%0b stall=%0b want 0/0/0", ctrl_state, mem_timeout, pipe_stall);
    end
    m_streak = 0; m_stall = 0; m_flush = 0; m_err = 0;
    rst = 1; idle_inputs(); #1;
  endtask

  task automatic test_stall_branch();
    do_reset();
    exmem_mem_write = 1; dmem_ready = 0; exmem_branch = 1; exmem_alu_zero = 1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pc_sel, ifid_flush, idex_flush, exmem_flush, pipe_stall} !== 5'b00001) begin
        failures++; $display("FAIL stall_branch_c%0d got %b want 00001", i, {pc_sel, ifid_flush, idex_flush, exmem_flush, pipe_stall});
      end
      tick();
    end
    dmem_ready = 1; #1;
    checks++;
    if ({pc_sel, ifid_flush, idex_flush, exmem_flush, pipe_stall} !== 5'b11110) begin
      failures++; $display("FAIL stall_branch_go got %b want 11110", {pc_sel, ifid_flush, idex_flush, exmem_flush, pipe_stall});
    end
    tick(); idle_inputs(); #1;
  endtask

  task automatic test_random();
    logic [7:0] got, exp, mask;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ifid_rs1 = 5'($urandom_range(0, 3)); ifid_rs2 = 5'($urandom_range(0, 3));
      idex_rd = 5'($urandom_range(0, 3)); idex_mem_read = 1'($urandom);
      exmem_branch = 1'($urandom); exmem_alu_zero = 1'($urandom);
      exmem_pc_branch = {$urandom, $urandom};
      exmem_mem_read = ($urandom_range(0, 3) == 0); exmem_mem_write = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      #1;
      got = {pc_write, ifid_write, idex_bubble, pipe_stall, ifid_flush, idex_flush, exmem_flush, pc_sel};
      exp = model_out();
      mask = (exp == 8'b1100_1111) ? 8'b1011_1111 : 8'hFF;
      checks++;
      if ((got & mask) !== (exp & mask) || pc_target !== exmem_pc_branch) begin
        failures++; $display("FAIL rand_comb cyc=%0d got %b want %b", i, got, exp);
      end
      checks++;
      if (ctrl_state !== (m_err ? 2 : (m_streak > 0 ? 1 : 0)) || mem_timeout !== m_err ||
          stall_cycles !== CW'(m_stall) || flush_events !== CW'(m_flush)) begin
        failures++;
        $display("FAIL rand_state cyc=%0d got st=%0d to=%0b sc=%0d fe=%0d want err=%0b streak=%0d sc=%0d fe=%0d",
                 i, ctrl_state, mem_timeout, stall_cycles, flush_events, m_err, m_streak, m_stall, m_flush);
      end
      tick();
    end
    idle_inputs(); #1;
  endtask

  task automatic test_saturation();
    do_reset();
    exmem_mem_read = 1; dmem_ready = 0;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (stall_cycles !== '1) begin failures++; $display("FAIL sat_stall got %0d want 255", stall_cycles); end
    do_reset();
    idle_inputs(); exmem_branch = 1; exmem_alu_zero = 1;
    for (int i = 0; i < 260; i++) tick();
    checks++;
    if (flush_events !== '1 || flush_events !== CW'(m_flush)) begin
      failures++; $display("FAIL sat_flush got %0d want 255", flush_events);
    end
    idle_inputs(); #1;
  endtask

  initial begin
    m_streak = 0; m_stall = 0; m_flush = 0; m_err = 0;
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_stall_branch();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
